mem_arb_ctrl: RTL and testbench

- Clocked sequencer and two-port arbiter for the team's 64x64-bit asynchronous, level-sensitive memory.
- The memory has a shared bidirectional 64-bit data bus, MemWr/MemRd strobes and a 6-bit Addr.
- Accepts word read/write requests from two independent requesters and grants them round-robin.
- Generates setup / strobe / recovery timing on the memory pins, captures read data and returns a one-cycle response to the owning requester.

---
 rtl/mem_arb_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_ctrl.sv
// Two-port round-robin arbiter and setup/strobe/recover sequencer for a
// 2^AW x DW asynchronous, level-sensitive memory with a shared data bus.
module mem_arb_ctrl #(
  parameter int ACC_CYCLES = 2,
  parameter int AW         = 6,
  parameter int DW         = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic          mem_rd,
  inout  wire  [DW-1:0] mem_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          ptr_r;
  logic          owner_r;
  logic          we_r;
  logic          drive_r;
  logic [DW-1:0] wdata_r;
  logic          grant0_s;
  logic          grant1_s;

  // Round-robin grant: ptr_r=0 favours requester 0 when both are valid.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && (!req1_valid || !ptr_r)) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Bus is driven from SETUP through RECOVER of a write; reset releases it at once.
  assign mem_data = drive_r ? wdata_r : {DW{1'bz}};

  // Access sequencer; every memory-side and response output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      ptr_r      <= 1'b0;
      owner_r    <= 1'b0;
      we_r       <= 1'b0;
      drive_r    <= 1'b0;
      wdata_r    <= {DW{1'b0}};
      mem_addr   <= {AW{1'b0}};
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= {DW{1'b0}};
      rsp1_rdata <= {DW{1'b0}};
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            state_r  <= SETUP;
            owner_r  <= grant1_s;
            ptr_r    <= ~grant1_s;
            we_r     <= grant1_s ? req1_we : req0_we;
            drive_r  <= grant1_s ? req1_we : req0_we;
            mem_addr <= grant1_s ? req1_addr : req0_addr;
            wdata_r  <= grant1_s ? req1_wdata : req0_wdata;
            busy     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          state_r <= ACCESS;
          cnt_r   <= CNT_LAST;
          mem_wr  <= we_r;
          mem_rd  <= ~we_r;
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            state_r <= RECOVER;
            mem_wr  <= 1'b0;
            mem_rd  <= 1'b0;
            // Read data is sampled while the strobe is still high on this edge.
            if (owner_r) begin
              rsp1_valid <= 1'b1;
              if (!we_r) begin
                rsp1_rdata <= mem_data;
              end else begin
                rsp1_rdata <= rsp1_rdata;
              end
            end else begin
              rsp0_valid <= 1'b1;
              if (!we_r) begin
                rsp0_rdata <= mem_data;
              end else begin
                rsp0_rdata <= rsp0_rdata;
              end
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RECOVER: begin
          state_r <= IDLE;
          drive_r <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          drive_r <= 1'b0;
          mem_wr  <= 1'b0;
          mem_rd  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: transaction-level model of the arbiter and access
// timeline checked every cycle, with directed and randomized request traffic.
module tb_mem_arb_ctrl;
  localparam int ACC = 2;
  localparam int AW  = 6;
  localparam int DW  = 64;
  localparam logic [DW-1:0] BUS_IDLE = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, rsp0_valid, req1_ready, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr, mem_rd, busy;
  wire  [DW-1:0] mem_data;

  int ncmp = 0;
  int nbad = 0;

  mem_arb_ctrl #(.ACC_CYCLES(ACC), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_data(mem_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a);
    return {32'hC0DE_0000 + 32'(a), 32'h1234_5600 + 32'(a)};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory device: undriven bus floats high so a released bus is observable.
  logic [DW-1:0] ext_mem [0:63];
  logic          mem_init = 1'b0;
  pullup (mem_data);
  assign mem_data = mem_rd ? ext_mem[mem_addr] : {DW{1'bz}};
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 64; a++) ext_mem[a] <= pat(a);
      mem_init <= 1'b1;
    end else if (rst_n && mem_wr) begin
      ext_mem[mem_addr] <= mem_data;
    end
  end

  // Reference model: one transaction at a time, outputs derived from the
  // number of cycles elapsed since the accepting handshake.
  bit            act = 1'b0, ptr = 1'b0, m_we, m_own, e0, e1, strobe, last;
  int            cyc = 0, t0 = 0, k;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdv, rd_exp0, rd_exp1;
  logic [DW-1:0] mmem [0:63];
  int            gnt_q[$];

  always @(negedge clk) begin
    if (cyc == 0) for (int a = 0; a < 64; a++) mmem[a] = pat(a);
    if (!rst_n) begin
      act = 1'b0; ptr = 1'b0; rd_exp0 = '0; rd_exp1 = '0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr", mem_wr, 1'b0);
      chk("rst_rd", mem_rd, 1'b0);
      chk("rst_addr", mem_addr, '0);
      chk("rst_bus", mem_data, BUS_IDLE);
      chk("rst_rsp0", rsp0_valid, 1'b0);
      chk("rst_rsp1", rsp1_valid, 1'b0);
      chk("rst_rdata0", rsp0_rdata, '0);
      chk("rst_rdata1", rsp1_rdata, '0);
    end else if (!act) begin
      e0 = req0_valid && (!req1_valid || !ptr);
      e1 = req1_valid && !e0;
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_wr", mem_wr, 1'b0);
      chk("idle_rd", mem_rd, 1'b0);
      chk("idle_bus", mem_data, BUS_IDLE);
      chk("idle_rsp0", rsp0_valid, 1'b0);
      chk("idle_rsp1", rsp1_valid, 1'b0);
      if (e0 || e1) begin
        act = 1'b1; t0 = cyc; m_own = e1; ptr = !e1;
        m_we   = e1 ? req1_we : req0_we;
        m_addr = e1 ? req1_addr : req0_addr;
        m_wd   = e1 ? req1_wdata : req0_wdata;
        gnt_q.push_back(e1 ? 1 : 0);
        if (m_we) mmem[m_addr] = m_wd;
        else m_rdv = mmem[m_addr];
      end
    end else begin
      k = cyc - t0;
      strobe = (k >= 2) && (k <= ACC + 1);
      last = (k == ACC + 2);
      chk("busy_ready0", req0_ready, 1'b0);
      chk("busy_ready1", req1_ready, 1'b0);
      chk("busy", busy, 1'b1);
      chk("addr", mem_addr, m_addr);
      chk("mem_wr", mem_wr, strobe && m_we);
      chk("mem_rd", mem_rd, strobe && !m_we);
      chk("bus", mem_data, m_we ? m_wd : (strobe ? m_rdv : BUS_IDLE));
      chk("rsp0_valid", rsp0_valid, last && !m_own);
      chk("rsp1_valid", rsp1_valid, last && m_own);
      if (last) begin
        if (!m_we && !m_own) rd_exp0 = m_rdv;
        if (!m_we && m_own) rd_exp1 = m_rdv;
        act = 1'b0;
      end
    end
    if (rst_n) begin
      chk("rdata0", rsp0_rdata, rd_exp0);
      chk("rdata1", rsp1_rdata, rd_exp1);
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_req(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    if (p) begin req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d; end
    else   begin req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d; end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = p ? req1_ready : req0_ready;
      @(posedge clk); #1;
    end
    chk(p ? "hs_timeout1" : "hs_timeout0", ok, 1'b1);
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 3);
    return (r == 3) ? 6'd63 : 6'(r);
  endfunction

  initial begin
    int base;
    logic [DW-1:0] wd;
    tick(3);
    #1 rst_n = 1'b1;
    tick(1);

    // Both requesters reading 0x00 / 0x3F every cycle: grants alternate.
    base = gnt_q.size();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd63;
    tick(4 * (ACC + 3) + 2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", 64'(gnt_q.size() - base >= 4), 1'b1);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (base + i < gnt_q.size()) ? 64'(gnt_q[base + i]) : '1, 64'(i % 2));
    tick(ACC + 4);
    chk("rr_rdata0_lit", rsp0_rdata, pat(0));
    chk("rr_rdata1_lit", rsp1_rdata, pat(63));

    // Port 0 write then read of 0x05.
    do_req(1'b0, 1'b1, 6'h05, 64'hDEADBEEF_CAFEF00D);
    do_req(1'b0, 1'b0, 6'h05, '0);
    tick(ACC + 3);
    chk("p0_read_lit", rsp0_rdata, 64'hDEADBEEF_CAFEF00D);

    // Write by port 0, immediate read by port 1.
    do_req(1'b0, 1'b1, 6'h2A, 64'h0F1E_2D3C_4B5A_6978);
    do_req(1'b1, 1'b0, 6'h2A, '0);
    tick(ACC + 3);
    chk("x_read_lit", rsp1_rdata, 64'h0F1E_2D3C_4B5A_6978);

    // Only requester 1, reads 0x3F, 0x00, 0x3F back to back.
    do_req(1'b1, 1'b0, 6'h3F, '0);
    do_req(1'b1, 1'b0, 6'h00, '0);
    do_req(1'b1, 1'b0, 6'h3F, '0);
    tick(ACC + 3);
    chk("p1_read_lit", rsp1_rdata, pat(63));

    // Reset during the second strobe cycle of a write.
    tick(ACC + 4);
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd7; req0_wdata = 64'h0123_4567_89AB_CDEF;
    tick(1);
    req0_valid = 1'b0;
    tick(2);
    chk("midop_wr_high", mem_wr, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wr", mem_wr, 1'b0);
    chk("async_bus", mem_data, BUS_IDLE);
    chk("async_busy", busy, 1'b0);
    @(posedge clk); #2;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd63;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1'b1);
    chk("post_rst_ready1", req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Randomized traffic on both ports.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_we    = 1'($urandom_range(0, 1));
      req0_addr  = rnd_addr();
      wd         = {$urandom, $urandom};
      req0_wdata = wd;
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_we    = 1'($urandom_range(0, 1));
      req1_addr  = rnd_addr();
      wd         = {$urandom, $urandom};
      req1_wdata = wd;
      tick(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(ACC + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
